// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side valid/ready handshake carrying FIFO head data and error flags
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8
);
  logic             Rd_valid;
  logic             Rd_ready;
  logic [WIDTH-1:0] Rd_data;
  logic             Rd_parity_err;
  logic             Rd_stop_err;
  modport master (output Rd_valid, Rd_data, Rd_parity_err, Rd_stop_err, input Rd_ready);
  modport slave  (input Rd_valid, Rd_data, Rd_parity_err, Rd_stop_err, output Rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority vote, feeding a FWFT FIFO with per-frame error flags
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PRE_W = 6
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       S_Data,
  input  logic [PRE_W-1:0]           Prescale,
  input  logic [$clog2(WIDTH+1)-1:0] Data_len,
  input  logic                       Parity_EN,
  input  logic                       Parity_type,
  input  logic                       Stop2,
  uart_rx_fifo_if.master             rd,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       Overrun
);
  localparam int BW = $clog2(WIDTH+4);
  localparam int DW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t           state_q, state_d;
  logic             s1_q, rx_q;
  logic [PRE_W-1:0] ecnt_q, ecnt_d, h, h_m1, h_p1, p_m1;
  logic [BW-1:0]    bit_q, bit_d, last;
  logic [1:0]       smp_q, smp_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             par_q, par_d, perr_q, perr_d, serr_q, serr_d;
  logic             maj, dec, bit_end, push, pop, push_ok;
  logic [DW-1:0]    di;
  logic [WIDTH+1:0] mem_q [DEPTH];
  logic [WIDTH+1:0] head;
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q;
  assign h       = Prescale >> 1;
  assign h_m1    = h - 1'b1;
  assign h_p1    = h + 1'b1;
  assign p_m1    = Prescale - 1'b1;
  assign dec     = ecnt_q == h_p1;
  assign bit_end = ecnt_q == p_m1;
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_q) | (smp_q[1] & rx_q);
  assign di      = DW'(bit_q - BW'(1));
  assign last    = BW'(Data_len) + BW'(Parity_EN) + BW'(Stop2) + BW'(1);
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_q <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      s1_q <= S_Data;
      rx_q <= s1_q;
    end
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      ecnt_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ecnt_d  = ecnt_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    data_d  = data_q;
    par_d   = par_q;
    perr_d  = perr_q;
    serr_d  = serr_q;
    push    = 1'b0;
    if (state_q != IDLE && state_q != WAIT_HIGH) begin
      ecnt_d   = bit_end ? '0 : ecnt_q + 1'b1;
      bit_d    = bit_end ? bit_q + 1'b1 : bit_q;
      smp_d[0] = (ecnt_q == h_m1) ? rx_q : smp_q[0];
      smp_d[1] = (ecnt_q == h) ? rx_q : smp_q[1];
    end
    case (state_q)
      IDLE: if (!rx_q) begin
        state_d = START;
        ecnt_d  = PRE_W'(1);
        bit_d   = '0;
        data_d  = '0;
        par_d   = 1'b0;
        perr_d  = 1'b0;
        serr_d  = 1'b0;
      end
      START: if (dec && maj) begin
        state_d = IDLE;
        ecnt_d  = '0;
        bit_d   = '0;
      end else if (bit_end) state_d = DATA;
      DATA: begin
        if (dec) begin
          data_d[di] = maj;
          par_d      = par_q ^ maj;
        end
        if (bit_end && bit_q == BW'(Data_len)) state_d = Parity_EN ? PARITY : STOP;
      end
      PARITY: begin
        perr_d  = dec ? par_q ^ maj ^ Parity_type : perr_q;
        state_d = bit_end ? STOP : PARITY;
      end
      STOP: if (dec) begin
        serr_d = serr_q | ~maj;
        if (bit_q == last) begin
          push    = 1'b1;
          state_d = serr_d ? WAIT_HIGH : IDLE;
          ecnt_d  = '0;
          bit_d   = '0;
        end
      end
      WAIT_HIGH: state_d = rx_q ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  // A full FIFO still accepts a frame when the head is popped in the same cycle.
  assign pop     = rd.Rd_valid & rd.Rd_ready;
  assign push_ok = push & ((cnt_q != CW'(DEPTH)) | pop);
  assign Overrun = push & ~push_ok;
  assign Level   = cnt_q;
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wp_q] <= {data_q, perr_q, serr_d};
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= push_ok ? wp_q + 1'b1 : wp_q;
      rp_q  <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
    end
  end
  assign head             = mem_q[rp_q];
  assign rd.Rd_valid      = cnt_q != '0;
  assign rd.Rd_data       = rd.Rd_valid ? head[WIDTH+1:2] : '0;
  assign rd.Rd_parity_err = rd.Rd_valid & head[1];
  assign rd.Rd_stop_err   = rd.Rd_valid & head[0];
endmodule
